// File: rtl/perip_bridge.sv
`default_nettype none
// ============================================================================
// Module   : perip_bridge
// Brief    : CPU peripheral-port responder: DRAM, SW/KEY, SEG/LED, ms counter.
// Revision : 1.0
// ============================================================================
module perip_bridge #(
    parameter int DRAM_AW  = 16,
    parameter int CNT_DIV  = 50000,
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] perip_addr,
    input  logic        perip_wen,
    input  logic [3:0]  perip_mask,
    input  logic [31:0] perip_wdata,
    output logic [31:0] perip_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dn_seg
);
    localparam logic [13:0] c_dram_tag = 14'h2004;
    localparam logic [29:0] c_sw_wa    = 30'h2008_0000;
    localparam logic [29:0] c_key_wa   = 30'h2008_0004;
    localparam logic [29:0] c_seg_wa   = 30'h2008_0008;
    localparam logic [29:0] c_led_wa   = 30'h2008_0010;
    localparam logic [29:0] c_cnt_wa   = 30'h2008_0014;
    localparam int c_cnt_w  = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam int c_scan_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(CNT_DIV - 1);
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} cnt_state_t;

    logic [29:0]        w_wa;
    logic               w_dram_sel;
    logic [DRAM_AW-1:0] w_dram_idx;
    logic               w_cnt_cmd;
    logic               w_cmd_start;
    logic               w_cmd_stop;
    logic               w_unused;

    logic [31:0] r_dram [0:(2**DRAM_AW)-1];
    logic [31:0] r_seg;
    logic [23:0] r_led;

    cnt_state_t         r_state, w_state_nxt;
    logic [31:0]        r_cnt_val, w_cnt_val_nxt;
    logic [c_cnt_w-1:0] r_cnt_pre, w_cnt_pre_nxt;

    logic [c_scan_w-1:0] r_scan_pre;
    logic [2:0]          r_scan_idx;
    logic [3:0]          w_nibble;

    assign w_wa       = perip_addr[31:2];
    assign w_dram_sel = (perip_addr[31:18] == c_dram_tag);
    assign w_dram_idx = perip_addr[DRAM_AW+1:2];
    assign w_unused   = ^perip_addr[1:0];

    // Counter commands need a full-word write with an exact code
    assign w_cnt_cmd   = perip_wen && (w_wa == c_cnt_wa) && (perip_mask == 4'hF);
    assign w_cmd_start = w_cnt_cmd && (perip_wdata == 32'h8000_0000);
    assign w_cmd_stop  = w_cnt_cmd && (perip_wdata == 32'hFFFF_FFFF);

    // DRAM is deliberately outside reset so contents survive it
    always_ff @(posedge clk) begin
        if (perip_wen && w_dram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (perip_mask[i]) begin
                    r_dram[w_dram_idx][8*i +: 8] <= perip_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        perip_rdata = 32'h0;
        if (w_dram_sel) begin
            perip_rdata = r_dram[w_dram_idx];
        end else begin
            case (w_wa)
                c_sw_wa:  perip_rdata = {8'h0, sw};
                c_key_wa: perip_rdata = {27'h0, button};
                c_seg_wa: perip_rdata = r_seg;
                c_led_wa: perip_rdata = {8'h0, r_led};
                c_cnt_wa: perip_rdata = r_cnt_val;
                default:  perip_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_seg <= 32'h0;
            r_led <= 24'h0;
        end else if (perip_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (perip_mask[i] && (w_wa == c_seg_wa)) begin
                    r_seg[8*i +: 8] <= perip_wdata[8*i +: 8];
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (perip_mask[i] && (w_wa == c_led_wa)) begin
                    r_led[8*i +: 8] <= perip_wdata[8*i +: 8];
                end
            end
        end
    end

    assign led = r_led;

    // Commands take priority over a prescaler tick in the same cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_val_nxt = r_cnt_val;
        w_cnt_pre_nxt = r_cnt_pre;
        if (w_cmd_start) begin
            w_state_nxt   = S_RUN;
            w_cnt_val_nxt = 32'h0;
            w_cnt_pre_nxt = '0;
        end else if (w_cmd_stop) begin
            w_state_nxt = S_IDLE;
        end else if (r_state == S_RUN) begin
            if (r_cnt_pre == c_cnt_last) begin
                w_cnt_pre_nxt = '0;
                w_cnt_val_nxt = r_cnt_val + 32'd1;
            end else begin
                w_cnt_pre_nxt = r_cnt_pre + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt_val <= 32'h0;
            r_cnt_pre <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt_val <= w_cnt_val_nxt;
            r_cnt_pre <= w_cnt_pre_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan_pre <= '0;
            r_scan_idx <= 3'd0;
        end else if (r_scan_pre == c_scan_last) begin
            r_scan_pre <= '0;
            r_scan_idx <= r_scan_idx + 3'd1;
        end else begin
            r_scan_pre <= r_scan_pre + 1'b1;
        end
    end

    assign dig_en   = ~(8'b1 << r_scan_idx);
    assign w_nibble = r_seg[{r_scan_idx, 2'b00} +: 4];

    always_comb begin
        dn_seg = 8'hFF;
        case (w_nibble)
            4'h0: dn_seg = 8'hC0;
            4'h1: dn_seg = 8'hF9;
            4'h2: dn_seg = 8'hA4;
            4'h3: dn_seg = 8'hB0;
            4'h4: dn_seg = 8'h99;
            4'h5: dn_seg = 8'h92;
            4'h6: dn_seg = 8'h82;
            4'h7: dn_seg = 8'hF8;
            4'h8: dn_seg = 8'h80;
            4'h9: dn_seg = 8'h90;
            4'hA: dn_seg = 8'h88;
            4'hB: dn_seg = 8'h83;
            4'hC: dn_seg = 8'hC6;
            4'hD: dn_seg = 8'hA1;
            4'hE: dn_seg = 8'h86;
            default: dn_seg = 8'h8E;
        endcase
    end
endmodule
`default_nettype wire

// File: doc/perip_bridge.md
# perip_bridge

Responder end of the CPU's DRAM/peripheral port (`perip_addr/perip_wen/perip_mask/perip_wdata/perip_rdata`). It decodes each access into one of four targets:
- on-chip DRAM;
- switch/button inputs;
- LED and 7-segment registers with display scanning;
- a start/stop millisecond counter.

It sits in the SoC top between the core's data port and the board I/O. Reads return data in the same cycle; writes commit on the clock edge.

## Interface
Parameters:
- `DRAM_AW`, 16: DRAM word-address width (2^16 words = 256 KiB).
- `CNT_DIV`, 50000: clock cycles per counter increment.
- `SCAN_DIV`, 50000: clock cycles per 7-segment digit slot.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `perip_addr` input 32: byte address of the access.
- `perip_wen` input 1: write strobe. 1 = write this cycle.
- `perip_mask` input 4: byte-lane enables for writes. Bit i enables `wdata[8i+7:8i]`.
- `perip_wdata` input 32: write data.
- `perip_rdata` output 32: read data, combinational from `perip_addr`.
- `sw` input 24: board switches.
- `button` input 5: board buttons.
- `led` output 24: LED register.
- `dig_en` output 8: 7-segment digit enables, active-low, one-hot-low.
- `dn_seg` output 8: segment code `{dp,g,f,e,d,c,b,a}`, active-low.

## Operation
Address map. The word address is `perip_addr[31:2]`; `perip_addr[1:0]` is ignored.
- `0x8010_0000`–`0x8013_FFFF`: DRAM, word index `perip_addr[DRAM_AW+1:2]`.
- `0x8020_0000` SW: read-only, returns `{8'h0, sw}`.
- `0x8020_0010` KEY: read-only, returns `{27'h0, button}`.
- `0x8020_0020` SEG: read/write, 32-bit display register.
- `0x8020_0040` LED: read/write, low 24 bits are significant. Reads return `{8'h0, led}`.
- `0x8020_0050` CNT: read returns the counter value. Writes are commands.
- Any other address: reads return 0, writes are ignored.

Write rules:
- DRAM, SEG and LED writes update only the lanes enabled in `perip_mask`. `mask = 0` writes nothing.
- A write to a read-only register has no effect.
- CNT accepts a command only when `mask = 4'hF`:
  - `wdata = 0x8000_0000` is START.
  - `wdata = 0xFFFF_FFFF` is STOP.
  - Any other value, or a partial mask, is ignored.

DRAM:
- Single port, asynchronous read, synchronous masked write.
- Contents are not cleared by reset.

Counter state machine (IDLE, RUN):
- IDLE + START → RUN. Value and prescaler are cleared to 0.
- RUN + START → RUN, with value and prescaler cleared (restart).
- RUN + STOP → IDLE. Value is held.
- IDLE + STOP: no change.
- In RUN, the prescaler counts 0…`CNT_DIV-1`. On the cycle it equals `CNT_DIV-1`, it returns to 0 and the value increments.
- The value wraps from `0xFFFF_FFFF` to 0.
- If a command and a tick occur in the same cycle, the command wins (the tick is dropped).

7-segment display:
- A scan index 0…7 advances once every `SCAN_DIV` cycles and wraps from 7 to 0. The scan runs continuously.
- `dig_en = ~(8'b1 << idx)`.
- `dn_seg` shows the hex code of `SEG[4*idx+3 : 4*idx]`, with dp off (bit 7 = 1).
- Codes for 0–F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.

## Timing
- Reads have zero latency. `perip_rdata` is valid in the same cycle as `perip_addr`.
- A write issued in cycle N is visible to a read in cycle N+1.
- A read and a write to the same DRAM word in the same cycle return the old data.
- CNT read-after-START: the read in cycle N+1 returns 0. The first increment is seen in cycle N+1+`CNT_DIV`.
- Outputs after reset, from the first edge with `rst = 0`:
  - `led = 0`, SEG = 0, counter value = 0, counter state IDLE, prescaler = 0.
  - Scan index = 0, so `dig_en = 8'hFE` and `dn_seg = 8'hC0`.
- `perip_rdata` after reset follows the decode of the current address.
- Reset asserted mid-count returns the block to the reset values above on that edge, regardless of any write in the same cycle.

## Test plan
- **DRAM masked write.** Write `0x1122_3344` mask `F` to `0x8010_0004`, then write `0xAABB_CCDD` mask `4'b0101`. The read returns `0x11BB_33DD`. A read of `0x8010_0008` is unaffected.
- **Read-only and unmapped.** With `sw = 0x00A5_5A5A` and `button = 5'b10011`: the SW read = `0x00A5_5A5A` and the KEY read = `0x0000_0013`. A write to SW leaves it unchanged. A read of `0x8030_0000` = 0 and a write there has no side effect.
- **Counter.** Run with `CNT_DIV = 4`:
  - START, then 4·5 cycles later CNT reads 5.
  - STOP, wait 20 cycles: still 5.
  - START again: reads 0 next cycle.
  - A write of `0x1234` or a partial-mask START is ignored.
  - Preload the value to `0xFFFF_FFFF` via force: the next tick wraps it to 0.
- **Display scan.** Run with `SCAN_DIV = 2` and SEG = `0x0123_ABCF`. Over 16 cycles `dig_en` steps FE, FD, …, 7F and wraps back to FE. `dn_seg` sequence: 8E C6 83 88 B0 A4 F9 C0.
- **LED and same-cycle behaviour.** Write LED = `0xFFFF_FFFF` mask `F`: reads `0x00FF_FFFF`. Issue START coincident with a tick: the value reads 0.
- **Reset mid-operation.** Counter in RUN, SEG and LED nonzero, then pull `rst` low for 1 cycle together with a LED write. Afterwards: `led = 0`, CNT = 0 and stays 0, `dig_en = FE`, `dn_seg = C0`, DRAM contents retained.
